// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the operand-forwarding control block.
//                ALUSrc select codes (the operand-mux encoding), register-ID
//                width and the pipeline stage record carried through EX,
//                MEM and WB.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int REG_AW = 4;   // 16 architectural registers, r0 reads as zero
  localparam int SEL_W  = 2;   // ALUSrc select width

  // Operand-mux select encoding; alu_src_a never uses SRC_IMM.
  localparam logic [SEL_W-1:0] SRC_REG   = 2'b00;
  localparam logic [SEL_W-1:0] SRC_EXMEM = 2'b01;
  localparam logic [SEL_W-1:0] SRC_MEMWB = 2'b10;
  localparam logic [SEL_W-1:0] SRC_IMM   = 2'b11;

  // Stage record field widths.
  localparam int REC_VALID_W = 1;
  localparam int REC_RD_W    = REG_AW;
  localparam int REC_WR_W    = 1;
  localparam int REC_LOAD_W  = 1;
  localparam int REC_W       = REC_VALID_W + REC_RD_W + REC_WR_W + REC_LOAD_W;

  typedef struct packed {
    logic                valid;
    logic [REC_RD_W-1:0] rd;
    logic                wr_en;
    logic                is_load;
  } stage_rec_t;

  localparam stage_rec_t REC_BUBBLE = '0;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/operand_fwd_ctrl_fwd_match.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_match
//  Description : Combinational hazard comparator for one source register.
//                Reports whether the source is produced by the instruction
//                currently in EX and/or the one currently in MEM. r0 never
//                matches since writes to it are discarded.
//  Ports       : src_i      - source register ID from decode
//                ex_rec_i   - current EX stage record
//                mem_rec_i  - current MEM stage record
//                hit_ex_o   - source produced by the EX instruction
//                hit_mem_o  - source produced by the MEM instruction
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_match
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] src_i,
  input  stage_rec_t        ex_rec_i,
  input  stage_rec_t        mem_rec_i,
  output logic              hit_ex_o,
  output logic              hit_mem_o
);

  logic w_src_nz;

  assign w_src_nz  = |src_i;
  assign hit_ex_o  = w_src_nz && ex_rec_i.valid  && ex_rec_i.wr_en  && (ex_rec_i.rd  == src_i);
  assign hit_mem_o = w_src_nz && mem_rec_i.valid && mem_rec_i.wr_en && (mem_rec_i.rd == src_i);

endmodule : fwd_match
`default_nettype wire

// File: rtl/operand_fwd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fwd_ctrl
//  Description : Generates the ALUSrc select codes for the A and B operand
//                muxes. Tracks in-flight destinations in EX/MEM/WB records,
//                picks regfile / EX-MEM / MEM-WB / immediate per operand and
//                raises a load-use stall (with an EX bubble) when a load
//                result is needed before it reaches WB.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                id_*             - decoded instruction fields and valid
//                flush            - squash the instruction entering EX
//                stall            - hold PC/IF/ID (combinational)
//                alu_src_a/_b     - registered operand selects, valid in EX
//                ex_valid         - EX holds a real instruction
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_fwd_ctrl #(
  parameter int REG_AW = 4,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              id_use_imm,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  alu_src_a,
  output logic [SEL_W-1:0]  alu_src_b,
  output logic              ex_valid
);

  import cpu_pkg::*;

  stage_rec_t ex_q, mem_q, wb_q;
  stage_rec_t ex_d;
  logic [SEL_W-1:0] src_a_q, src_a_d;
  logic [SEL_W-1:0] src_b_q, src_b_d;

  logic [REG_AW-1:0] w_src    [2];
  logic [1:0]        w_hit_ex;
  logic [1:0]        w_hit_mem;
  logic [SEL_W-1:0]  w_fwd_sel [2];
  logic              w_accept;

  assign w_src[0] = id_rs;
  assign w_src[1] = id_rt;

  // One comparator per operand; index 0 is A (rs), index 1 is B (rt).
  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
    fwd_match u_fwd_match (
      .src_i     (w_src[gi]),
      .ex_rec_i  (ex_q),
      .mem_rec_i (mem_q),
      .hit_ex_o  (w_hit_ex[gi]),
      .hit_mem_o (w_hit_mem[gi])
    );

    // The EX producer is younger than the MEM producer, so it takes priority.
    assign w_fwd_sel[gi] = w_hit_ex[gi]  ? SRC_EXMEM :
                           w_hit_mem[gi] ? SRC_MEMWB : SRC_REG;
  end

  // A load in EX has no data until WB; one bubble moves it to MEM, where the
  // MEM/WB path covers the hazard. Operand B is exempt when it is the immediate.
  assign stall = id_valid && ex_q.valid && ex_q.is_load &&
                 (w_hit_ex[0] || (!id_use_imm && w_hit_ex[1]));

  assign w_accept = id_valid && !flush && !stall;

  always_comb begin
    ex_d    = REC_BUBBLE;
    src_a_d = SRC_REG;
    src_b_d = SRC_REG;
    if (w_accept) begin
      ex_d.valid   = 1'b1;
      ex_d.rd      = id_rd;
      ex_d.wr_en   = id_wr_en;
      ex_d.is_load = id_is_load;
      src_a_d      = w_fwd_sel[0];
      src_b_d      = id_use_imm ? SRC_IMM : w_fwd_sel[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= REC_BUBBLE;
      mem_q   <= REC_BUBBLE;
      wb_q    <= REC_BUBBLE;
      src_a_q <= SRC_REG;
      src_b_q <= SRC_REG;
    end else begin
      wb_q    <= mem_q;
      mem_q   <= ex_q;
      ex_q    <= ex_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
    end
  end

  assign alu_src_a = src_a_q;
  assign alu_src_b = src_b_q;
  assign ex_valid  = ex_q.valid;

  // The WB record is the retirement slot of the tracked pipeline; no select
  // path reads it because a WB result is already visible through the regfile.
  logic unused_wb;
  assign unused_wb = ^wb_q;

endmodule : operand_fwd_ctrl
`default_nettype wire

// File: tb/tb_operand_fwd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
module tb_operand_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_wr_en, id_is_load, id_use_imm, flush;
  logic [3:0] id_rs, id_rt, id_rd;
  logic       stall, ex_valid;
  logic [1:0] alu_src_a, alu_src_b;

  operand_fwd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
    .id_use_imm(id_use_imm), .flush(flush), .stall(stall),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ex_valid(ex_valid)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: history of what entered EX, newest first.
  // hist[0] is now in EX, hist[1] in MEM, hist[2] in WB.
  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } rec_t;
  rec_t hist[3];

  bit obs_stall, exp_stall, exp_ev;
  int exp_a, exp_b;

  // Select code for a source: youngest producer among the two older in-flight
  // instructions (distance 0 -> EX/MEM forward, distance 1 -> MEM/WB forward).
  function automatic int model_sel(int s);
    if (s == 0) return 0;
    for (int d = 0; d < 2; d++)
      if (hist[d].v && hist[d].wr && hist[d].rd == s) return (d == 0) ? 1 : 2;
    return 0;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0};
  endfunction

  // Present one instruction for one cycle, starting just after a rising edge.
  // Samples stall before the edge and leaves the time #1 after the next edge.
  task automatic drive(input bit v, input int rs, input int rt, input int rd,
                       input bit wr, input bit ld, input bit imm, input bit fl);
    bit acc;
    id_valid = v; id_rs = 4'(rs); id_rt = 4'(rt); id_rd = 4'(rd);
    id_wr_en = wr; id_is_load = ld; id_use_imm = imm; flush = fl;
    #1;
    obs_stall = stall;
    exp_stall = v && hist[0].v && hist[0].ld &&
                (model_sel(rs) == 1 || (!imm && model_sel(rt) == 1));
    acc   = v && !fl && !exp_stall;
    exp_a = acc ? model_sel(rs) : 0;
    exp_b = acc ? (imm ? 3 : model_sel(rt)) : 0;
    exp_ev = acc;
    @(posedge clk);
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = '{acc, rd, wr, ld};
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    // Reset state right after power-up reset.
    n_cmp++;
    if (alu_src_a !== 2'b00 || alu_src_b !== 2'b00 || ex_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: a=%b b=%b ev=%b want a=00 b=00 ev=0", alu_src_a, alu_src_b, ex_valid);
    end
    // Fill EX/MEM/WB with valid records, the newest a load.
    drive(1, 1, 2, 1, 1, 0, 0, 0);
    drive(1, 1, 2, 2, 1, 0, 0, 0);
    drive(1, 1, 2, 3, 1, 1, 1, 0);
    id_valid = 1; id_rs = 4'd3; id_rt = 4'd2; id_rd = 4'd4;
    id_wr_en = 1; id_is_load = 0; id_use_imm = 0; flush = 0;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prestall: stall=%b want 1", stall);
    end
    rst_n = 0;
    #1;
    n_cmp++;
    if (alu_src_a !== 2'b00 || alu_src_b !== 2'b00 || ex_valid !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midrun: a=%b b=%b ev=%b stall=%b want 00 00 0 0",
               alu_src_a, alu_src_b, ex_valid, stall);
    end
    id_valid = 0;
    model_clear();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    idle(3);
    drive(1, 1, 2, 3, 1, 0, 0, 0);           // ADD r3,r1,r2
    n_cmp++;
    if (obs_stall !== 1'b0 || ex_valid !== 1'b1 || alu_src_a !== 2'b00 || alu_src_b !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_add: stall=%b ev=%b a=%b b=%b want 0 1 00 00", obs_stall, ex_valid, alu_src_a, alu_src_b);
    end
    drive(1, 3, 5, 4, 1, 0, 0, 0);           // SUB r4,r3,r5
    n_cmp++;
    if (obs_stall !== 1'b0 || ex_valid !== 1'b1 || alu_src_a !== 2'b01 || alu_src_b !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_sub: stall=%b ev=%b a=%b b=%b want 0 1 01 00", obs_stall, ex_valid, alu_src_a, alu_src_b);
    end
  endtask

  task automatic test_gap_forward();
    idle(3);
    drive(1, 1, 2, 3, 1, 0, 0, 0);           // ADD r3
    drive(0, 0, 0, 0, 0, 0, 0, 0);           // NOP
    n_cmp++;
    if (ex_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_nop_ev: ev=%b want 0", ex_valid);
    end
    drive(1, 2, 3, 6, 1, 0, 0, 0);           // AND r6,r2,r3
    n_cmp++;
    if (ex_valid !== 1'b1 || alu_src_a !== 2'b00 || alu_src_b !== 2'b10) begin
      n_fail++;
      $display("FAIL gap_and: ev=%b a=%b b=%b want 1 00 10", ex_valid, alu_src_a, alu_src_b);
    end
  endtask

  task automatic test_load_use();
    idle(3);
    drive(1, 1, 0, 7, 1, 1, 1, 0);           // LW r7
    drive(1, 7, 2, 1, 1, 0, 0, 0);           // ADD r1,r7,r2 -> stalled
    n_cmp++;
    if (obs_stall !== 1'b1 || ex_valid !== 1'b0 || alu_src_a !== 2'b00) begin
      n_fail++;
      $display("FAIL lu_stall: stall=%b ev=%b a=%b want 1 0 00", obs_stall, ex_valid, alu_src_a);
    end
    drive(1, 7, 2, 1, 1, 0, 0, 0);           // ADD retried
    n_cmp++;
    if (obs_stall !== 1'b0 || ex_valid !== 1'b1 || alu_src_a !== 2'b10 || alu_src_b !== 2'b00) begin
      n_fail++;
      $display("FAIL lu_release: stall=%b ev=%b a=%b b=%b want 0 1 10 00", obs_stall, ex_valid, alu_src_a, alu_src_b);
    end
  endtask

  task automatic test_imm_r0();
    idle(3);
    drive(1, 1, 3, 2, 1, 0, 0, 0);           // ADD r2
    drive(1, 2, 2, 2, 1, 0, 1, 0);           // ADDI r2,r2,#5
    n_cmp++;
    if (alu_src_a !== 2'b01 || alu_src_b !== 2'b11) begin
      n_fail++;
      $display("FAIL imm_fwd: a=%b b=%b want 01 11", alu_src_a, alu_src_b);
    end
    idle(3);
    drive(1, 1, 3, 0, 1, 0, 0, 0);           // ADD r0
    drive(1, 0, 0, 0, 1, 0, 0, 0);           // reads r0 both operands
    n_cmp++;
    if (alu_src_a !== 2'b00 || alu_src_b !== 2'b00 || ex_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL r0_nofwd: a=%b b=%b ev=%b want 00 00 1", alu_src_a, alu_src_b, ex_valid);
    end
  endtask

  task automatic test_flush();
    idle(3);
    drive(1, 1, 2, 5, 1, 0, 0, 0);           // ADD r5
    drive(1, 5, 5, 9, 1, 0, 0, 1);           // hazarding, flushed, would write r9
    n_cmp++;
    if (ex_valid !== 1'b0 || alu_src_a !== 2'b00 || alu_src_b !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_bubble: ev=%b a=%b b=%b want 0 00 00", ex_valid, alu_src_a, alu_src_b);
    end
    drive(1, 9, 9, 10, 1, 0, 0, 0);          // reads squashed r9
    n_cmp++;
    if (ex_valid !== 1'b1 || alu_src_a !== 2'b00 || alu_src_b !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_nofwd: ev=%b a=%b b=%b want 1 00 00", ex_valid, alu_src_a, alu_src_b);
    end
    // Flush together with a load-use hazard.
    idle(3);
    drive(1, 1, 0, 7, 1, 1, 1, 0);           // LW r7
    drive(1, 7, 2, 8, 1, 0, 0, 1);           // hazard + flush
    n_cmp++;
    if (obs_stall !== 1'b1 || ex_valid !== 1'b0 || alu_src_a !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_stall: stall=%b ev=%b a=%b want 1 0 00", obs_stall, ex_valid, alu_src_a);
    end
    drive(1, 7, 2, 8, 1, 0, 0, 0);
    n_cmp++;
    if (obs_stall !== 1'b0 || alu_src_a !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_stall_next: stall=%b a=%b want 0 10", obs_stall, alu_src_a);
    end
  endtask

  task automatic test_random();
    idle(3);
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(99) < 85, $urandom_range(7), $urandom_range(7), $urandom_range(7),
            $urandom_range(99) < 80, $urandom_range(99) < 25, $urandom_range(99) < 30,
            $urandom_range(99) < 8);
      n_cmp++;
      if (obs_stall !== exp_stall || ex_valid !== exp_ev ||
          alu_src_a !== 2'(exp_a) || alu_src_b !== 2'(exp_b)) begin
        n_fail++;
        $display("FAIL rand[%0d]: stall=%b ev=%b a=%b b=%b want stall=%b ev=%b a=%0d b=%0d",
                 i, obs_stall, ex_valid, alu_src_a, alu_src_b, exp_stall, exp_ev, exp_a, exp_b);
      end
    end
  endtask

  initial begin
    rst_n = 0;
    id_valid = 0; id_rs = '0; id_rt = '0; id_rd = '0;
    id_wr_en = 0; id_is_load = 0; id_use_imm = 0; flush = 0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_gap_forward();
    test_load_use();
    test_imm_r0();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
